// File: rtl/irq_ctrl_if.sv
// ----------------------------------------------------------------------------
// irq_ctrl_if
//   CPU-side register/handshake bundle of the interrupt controller.
//
//   Parameters
//     WIDTH      vector width; the controller serves N = 1 << WIDTH sources
//
//   Signals (direction seen from the CPU, i.e. the master modport)
//     en_we      out  write strobe for the enable register
//     en_wdata   out  N-bit enable mask loaded on en_we
//     clr_we     out  write strobe for pending-clear
//     clr_wdata  out  N-bit write-1-to-clear mask for pending
//     ack        out  CPU accepts the presented interrupt
//     eoi        out  CPU finished servicing the interrupt
//     irq        in   interrupt request
//     vector     in   WIDTH-bit index of the presented source
//     busy       in   an interrupt is in service
//     pending    in   pending register readback
//     enable     in   enable register readback
//
//   The controller connects through the slave modport.
// ----------------------------------------------------------------------------
interface irq_ctrl_if #(
    parameter int WIDTH = 4
);
    localparam int N = 1 << WIDTH;

    logic             en_we;
    logic [N-1:0]     en_wdata;
    logic             clr_we;
    logic [N-1:0]     clr_wdata;
    logic             ack;
    logic             eoi;
    logic             irq;
    logic [WIDTH-1:0] vector;
    logic             busy;
    logic [N-1:0]     pending;
    logic [N-1:0]     enable;

    modport master (
        output en_we,
        output en_wdata,
        output clr_we,
        output clr_wdata,
        output ack,
        output eoi,
        input  irq,
        input  vector,
        input  busy,
        input  pending,
        input  enable
    );

    modport slave (
        input  en_we,
        input  en_wdata,
        input  clr_we,
        input  clr_wdata,
        input  ack,
        input  eoi,
        output irq,
        output vector,
        output busy,
        output pending,
        output enable
    );
endinterface

// File: rtl/irq_ctrl.sv
// ----------------------------------------------------------------------------
// irq_ctrl
//   Edge-triggered interrupt controller for N = 1 << WIDTH sources.
//   Rising edges on src are latched into a pending register, masked by an
//   enable register, and the highest-numbered active source is presented to
//   the CPU as irq/vector. The request is sequenced through an ack / eoi
//   handshake so that only one interrupt is ever in service.
//
//   Ports
//     clk   in   system clock, all state changes on the rising edge
//     rst   in   synchronous active-high reset
//     src   in   N interrupt source levels; a 0->1 transition is an event
//     bus   slave side of irq_ctrl_if (register writes, ack/eoi handshake,
//           irq/vector/busy and pending/enable readback)
//
//   Also contains prio_enc, the highest-index-wins priority encoder used for
//   source selection.
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// prio_enc
//   Priority encoder: idx is the highest set index of req, valid = |req.
//   idx is 0 when req is all zero.
//
//   Ports
//     req    in   N request bits
//     idx    out  WIDTH-bit index of the highest set request
//     valid  out  at least one request bit is set
// ----------------------------------------------------------------------------
module prio_enc #(
    parameter int WIDTH = 4
) (
    input  logic [(1 << WIDTH)-1:0] req,
    output logic [WIDTH-1:0]        idx,
    output logic                    valid
);
    localparam int N = 1 << WIDTH;

    // Ascending scan: every later (higher) set bit overwrites the result,
    // so the highest set index is what remains at the end.
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                idx = WIDTH'(i);
            end else begin
                idx = idx;
            end
        end
    end

    assign valid = |req;
endmodule

module irq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [(1 << WIDTH)-1:0] src,
    irq_ctrl_if.slave               bus
);
    localparam int N = 1 << WIDTH;

    // Handshake FSM encoding; 2'b11 is unused and recovers to idle.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // Registered state
    logic [1:0]       state_r;
    logic [WIDTH-1:0] vector_r;
    logic [N-1:0]     pending_r;
    logic [N-1:0]     enable_r;
    logic [N-1:0]     src_q_r;
    logic             irq_r;
    logic             busy_r;

    // Combinational next-state and helper terms
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] vector_nxt_s;
    logic [N-1:0]     pending_nxt_s;
    logic [N-1:0]     enable_nxt_s;
    logic [N-1:0]     event_s;
    logic [N-1:0]     masked_s;
    logic [N-1:0]     clr_mask_s;
    logic [N-1:0]     ack_mask_s;
    logic [WIDTH-1:0] sel_s;
    logic             any_s;
    logic             ack_take_s;

    // Source history for edge detection. It is loaded during reset as well,
    // so a source already high when reset is released is not an event.
    always_ff @(posedge clk) begin
        src_q_r <= src;
    end

    assign event_s  = src & ~src_q_r;

    // Selection always works on the current register contents.
    assign masked_s = pending_r & enable_r;

    prio_enc #(
        .WIDTH (WIDTH)
    ) u_prio_enc (
        .req   (masked_s),
        .idx   (sel_s),
        .valid (any_s)
    );

    // Handshake FSM next-state and vector selection. In REQ an ack wins over
    // everything else; without ack the vector follows the current winner, so a
    // higher source can preempt before acknowledge, and a withdrawn request
    // (cleared or disabled) falls back to idle.
    always_comb begin
        state_nxt_s  = state_r;
        vector_nxt_s = vector_r;
        ack_take_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_s) begin
                    state_nxt_s  = ST_REQ;
                    vector_nxt_s = sel_s;
                end else begin
                    state_nxt_s  = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.ack) begin
                    state_nxt_s = ST_SERVICE;
                    ack_take_s  = 1'b1;
                end else if (any_s) begin
                    state_nxt_s  = ST_REQ;
                    vector_nxt_s = sel_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (bus.eoi) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SERVICE;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                vector_nxt_s = '0;
            end
        endcase
    end

    // Pending update: software clear and accepted-ack clear are merged into
    // one clear mask; new events are OR-ed in last so a set always beats a
    // clear in the same cycle and no event is lost.
    always_comb begin
        ack_mask_s           = '0;
        ack_mask_s[vector_r] = ack_take_s;
        if (bus.clr_we) begin
            clr_mask_s = bus.clr_wdata | ack_mask_s;
        end else begin
            clr_mask_s = ack_mask_s;
        end
        pending_nxt_s = (pending_r & ~clr_mask_s) | event_s;
    end

    // Enable register write; independent of any clear in the same cycle.
    always_comb begin
        if (bus.en_we) begin
            enable_nxt_s = bus.en_wdata;
        end else begin
            enable_nxt_s = enable_r;
        end
    end

    // Controller state registers. irq and busy are registered decodes of the
    // next state, so they always equal (state == REQ) / (state == SERVICE)
    // without any combinational path from inputs to outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            vector_r  <= '0;
            pending_r <= '0;
            enable_r  <= '0;
            irq_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            vector_r  <= vector_nxt_s;
            pending_r <= pending_nxt_s;
            enable_r  <= enable_nxt_s;
            irq_r     <= (state_nxt_s == ST_REQ);
            busy_r    <= (state_nxt_s == ST_SERVICE);
        end
    end

    assign bus.irq     = irq_r;
    assign bus.busy    = busy_r;
    assign bus.vector  = vector_r;
    assign bus.pending = pending_r;
    assign bus.enable  = enable_r;
endmodule

// File: tb/tb_irq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_irq_ctrl
//   Self-checking bench for irq_ctrl with WIDTH=4. Each scenario task walks a
//   short cycle sequence: per cycle it drives the inputs, pushes the expected
//   post-edge outputs to a scoreboard queue, lets the edge happen and then
//   pops and compares against the DUT outputs sampled 1 time unit later.
// ----------------------------------------------------------------------------
module tb_irq_ctrl;
    logic        clk;
    logic        rst;
    logic [15:0] src;

    irq_ctrl_if #(.WIDTH(4)) bus ();

    irq_ctrl #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .src (src),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        irq;
        logic        busy;
        logic [3:0]  vec;
        logic [15:0] pend;
        logic [15:0] en;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push_exp(input logic i, input logic b, input logic [3:0] v,
                            input logic [15:0] p, input logic [15:0] e);
        exp_t x;
        x.irq  = i;
        x.busy = b;
        x.vec  = v;
        x.pend = p;
        x.en   = e;
        sb.push_back(x);
    endtask

    task automatic quiet();
        bus.en_we     = 1'b0;
        bus.en_wdata  = 16'h0000;
        bus.clr_we    = 1'b0;
        bus.clr_wdata = 16'h0000;
        bus.ack       = 1'b0;
        bus.eoi       = 1'b0;
    endtask

    // Reset values, source held high through reset, then enable all.
    task automatic test_reset();
        exp_t x;
        for (int c = 0; c < 5; c++) begin
            quiet();
            case (c)
                0: begin rst = 1'b1; src = 16'h0004; push_exp(1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000); end
                1: begin rst = 1'b0; push_exp(1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000); end
                2: begin bus.en_we = 1'b1; bus.en_wdata = 16'hFFFF; push_exp(1'b0, 1'b0, 4'd0, 16'h0000, 16'hFFFF); end
                3: push_exp(1'b0, 1'b0, 4'd0, 16'h0000, 16'hFFFF);
                default: begin src = 16'h0000; push_exp(1'b0, 1'b0, 4'd0, 16'h0000, 16'hFFFF); end
            endcase
            @(posedge clk); #1;
            x = sb.pop_front();
            checks++;
            if (bus.irq !== x.irq || bus.busy !== x.busy || bus.vector !== x.vec ||
                bus.pending !== x.pend || bus.enable !== x.en) begin
                errors++;
                $display("FAIL reset c%0d: irq=%b busy=%b vector=%0d pending=%h enable=%h, expected irq=%b busy=%b vector=%0d pending=%h enable=%h",
                         c, bus.irq, bus.busy, bus.vector, bus.pending, bus.enable, x.irq, x.busy, x.vec, x.pend, x.en);
            end
        end
    endtask

    // Single source: 2-cycle latency, ack, eoi.
    task automatic test_single();
        exp_t x;
        for (int c = 0; c < 6; c++) begin
            quiet();
            case (c)
                0: begin src = 16'h0020; push_exp(1'b0, 1'b0, 4'd0, 16'h0020, 16'hFFFF); end
                1: begin src = 16'h0000; push_exp(1'b1, 1'b0, 4'd5, 16'h0020, 16'hFFFF); end
                2: begin bus.ack = 1'b1; push_exp(1'b0, 1'b1, 4'd5, 16'h0000, 16'hFFFF); end
                3: push_exp(1'b0, 1'b1, 4'd5, 16'h0000, 16'hFFFF);
                4: begin bus.eoi = 1'b1; push_exp(1'b0, 1'b0, 4'd5, 16'h0000, 16'hFFFF); end
                default: push_exp(1'b0, 1'b0, 4'd5, 16'h0000, 16'hFFFF);
            endcase
            @(posedge clk); #1;
            x = sb.pop_front();
            checks++;
            if (bus.irq !== x.irq || bus.busy !== x.busy || bus.vector !== x.vec ||
                bus.pending !== x.pend || bus.enable !== x.en) begin
                errors++;
                $display("FAIL single c%0d: irq=%b busy=%b vector=%0d pending=%h enable=%h, expected irq=%b busy=%b vector=%0d pending=%h enable=%h",
                         c, bus.irq, bus.busy, bus.vector, bus.pending, bus.enable, x.irq, x.busy, x.vec, x.pend, x.en);
            end
        end
    endtask

    // Two simultaneous sources: highest first, the other re-presented after eoi.
    task automatic test_priority();
        exp_t x;
        for (int c = 0; c < 5; c++) begin
            quiet();
            case (c)
                0: begin src = 16'h1008; push_exp(1'b0, 1'b0, 4'd5, 16'h1008, 16'hFFFF); end
                1: begin src = 16'h0000; push_exp(1'b1, 1'b0, 4'd12, 16'h1008, 16'hFFFF); end
                2: begin bus.ack = 1'b1; push_exp(1'b0, 1'b1, 4'd12, 16'h0008, 16'hFFFF); end
                3: begin bus.eoi = 1'b1; push_exp(1'b0, 1'b0, 4'd12, 16'h0008, 16'hFFFF); end
                default: push_exp(1'b1, 1'b0, 4'd3, 16'h0008, 16'hFFFF);
            endcase
            @(posedge clk); #1;
            x = sb.pop_front();
            checks++;
            if (bus.irq !== x.irq || bus.busy !== x.busy || bus.vector !== x.vec ||
                bus.pending !== x.pend || bus.enable !== x.en) begin
                errors++;
                $display("FAIL priority c%0d: irq=%b busy=%b vector=%0d pending=%h enable=%h, expected irq=%b busy=%b vector=%0d pending=%h enable=%h",
                         c, bus.irq, bus.busy, bus.vector, bus.pending, bus.enable, x.irq, x.busy, x.vec, x.pend, x.en);
            end
        end
    endtask

    // Higher source preempts the presented vector before ack.
    task automatic test_preempt();
        exp_t x;
        for (int c = 0; c < 7; c++) begin
            quiet();
            case (c)
                0: begin src = 16'h0200; push_exp(1'b1, 1'b0, 4'd3, 16'h0208, 16'hFFFF); end
                1: begin src = 16'h0000; push_exp(1'b1, 1'b0, 4'd9, 16'h0208, 16'hFFFF); end
                2: begin bus.ack = 1'b1; push_exp(1'b0, 1'b1, 4'd9, 16'h0008, 16'hFFFF); end
                3: begin bus.eoi = 1'b1; push_exp(1'b0, 1'b0, 4'd9, 16'h0008, 16'hFFFF); end
                4: push_exp(1'b1, 1'b0, 4'd3, 16'h0008, 16'hFFFF);
                5: begin bus.ack = 1'b1; push_exp(1'b0, 1'b1, 4'd3, 16'h0000, 16'hFFFF); end
                default: begin bus.eoi = 1'b1; push_exp(1'b0, 1'b0, 4'd3, 16'h0000, 16'hFFFF); end
            endcase
            @(posedge clk); #1;
            x = sb.pop_front();
            checks++;
            if (bus.irq !== x.irq || bus.busy !== x.busy || bus.vector !== x.vec ||
                bus.pending !== x.pend || bus.enable !== x.en) begin
                errors++;
                $display("FAIL preempt c%0d: irq=%b busy=%b vector=%0d pending=%h enable=%h, expected irq=%b busy=%b vector=%0d pending=%h enable=%h",
                         c, bus.irq, bus.busy, bus.vector, bus.pending, bus.enable, x.irq, x.busy, x.vec, x.pend, x.en);
            end
        end
    endtask

    // Disabled source stays pending; enabling it raises irq 2 cycles later;
    // clearing it before ack withdraws the request.
    task automatic test_masking();
        exp_t x;
        for (int c = 0; c < 8; c++) begin
            quiet();
            case (c)
                0: begin bus.en_we = 1'b1; bus.en_wdata = 16'h0000; push_exp(1'b0, 1'b0, 4'd3, 16'h0000, 16'h0000); end
                1: begin src = 16'h0080; push_exp(1'b0, 1'b0, 4'd3, 16'h0080, 16'h0000); end
                2: begin src = 16'h0000; push_exp(1'b0, 1'b0, 4'd3, 16'h0080, 16'h0000); end
                3: begin bus.en_we = 1'b1; bus.en_wdata = 16'h0080; push_exp(1'b0, 1'b0, 4'd3, 16'h0080, 16'h0080); end
                4: push_exp(1'b1, 1'b0, 4'd7, 16'h0080, 16'h0080);
                5: begin bus.clr_we = 1'b1; bus.clr_wdata = 16'h0080; push_exp(1'b1, 1'b0, 4'd7, 16'h0000, 16'h0080); end
                6: push_exp(1'b0, 1'b0, 4'd7, 16'h0000, 16'h0080);
                default: begin bus.en_we = 1'b1; bus.en_wdata = 16'hFFFF; push_exp(1'b0, 1'b0, 4'd7, 16'h0000, 16'hFFFF); end
            endcase
            @(posedge clk); #1;
            x = sb.pop_front();
            checks++;
            if (bus.irq !== x.irq || bus.busy !== x.busy || bus.vector !== x.vec ||
                bus.pending !== x.pend || bus.enable !== x.en) begin
                errors++;
                $display("FAIL masking c%0d: irq=%b busy=%b vector=%0d pending=%h enable=%h, expected irq=%b busy=%b vector=%0d pending=%h enable=%h",
                         c, bus.irq, bus.busy, bus.vector, bus.pending, bus.enable, x.irq, x.busy, x.vec, x.pend, x.en);
            end
        end
    endtask

    // Set beats clear (software clear and ack clear); stray ack/eoi ignored.
    task automatic test_set_wins();
        exp_t x;
        for (int c = 0; c < 10; c++) begin
            quiet();
            case (c)
                0: begin src = 16'h0010; bus.clr_we = 1'b1; bus.clr_wdata = 16'h0010; push_exp(1'b0, 1'b0, 4'd7, 16'h0010, 16'hFFFF); end
                1: begin src = 16'h0000; push_exp(1'b1, 1'b0, 4'd4, 16'h0010, 16'hFFFF); end
                2: begin src = 16'h0010; bus.ack = 1'b1; push_exp(1'b0, 1'b1, 4'd4, 16'h0010, 16'hFFFF); end
                3: begin src = 16'h0000; push_exp(1'b0, 1'b1, 4'd4, 16'h0010, 16'hFFFF); end
                4: begin bus.eoi = 1'b1; push_exp(1'b0, 1'b0, 4'd4, 16'h0010, 16'hFFFF); end
                5: push_exp(1'b1, 1'b0, 4'd4, 16'h0010, 16'hFFFF);
                6: begin bus.ack = 1'b1; push_exp(1'b0, 1'b1, 4'd4, 16'h0000, 16'hFFFF); end
                7: begin bus.ack = 1'b1; push_exp(1'b0, 1'b1, 4'd4, 16'h0000, 16'hFFFF); end
                8: begin bus.eoi = 1'b1; push_exp(1'b0, 1'b0, 4'd4, 16'h0000, 16'hFFFF); end
                default: begin bus.eoi = 1'b1; bus.ack = 1'b1; push_exp(1'b0, 1'b0, 4'd4, 16'h0000, 16'hFFFF); end
            endcase
            @(posedge clk); #1;
            x = sb.pop_front();
            checks++;
            if (bus.irq !== x.irq || bus.busy !== x.busy || bus.vector !== x.vec ||
                bus.pending !== x.pend || bus.enable !== x.en) begin
                errors++;
                $display("FAIL set_wins c%0d: irq=%b busy=%b vector=%0d pending=%h enable=%h, expected irq=%b busy=%b vector=%0d pending=%h enable=%h",
                         c, bus.irq, bus.busy, bus.vector, bus.pending, bus.enable, x.irq, x.busy, x.vec, x.pend, x.en);
            end
        end
    endtask

    // Events accumulate during SERVICE; reset mid-service wins over eoi.
    task automatic test_reset_mid();
        exp_t x;
        for (int c = 0; c < 7; c++) begin
            quiet();
            case (c)
                0: begin src = 16'h0002; push_exp(1'b0, 1'b0, 4'd4, 16'h0002, 16'hFFFF); end
                1: begin src = 16'h0000; push_exp(1'b1, 1'b0, 4'd1, 16'h0002, 16'hFFFF); end
                2: begin bus.ack = 1'b1; push_exp(1'b0, 1'b1, 4'd1, 16'h0000, 16'hFFFF); end
                3: begin src = 16'h0040; push_exp(1'b0, 1'b1, 4'd1, 16'h0040, 16'hFFFF); end
                4: begin src = 16'h0000; rst = 1'b1; bus.eoi = 1'b1; push_exp(1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000); end
                5: begin rst = 1'b0; push_exp(1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000); end
                default: push_exp(1'b0, 1'b0, 4'd0, 16'h0000, 16'h0000);
            endcase
            @(posedge clk); #1;
            x = sb.pop_front();
            checks++;
            if (bus.irq !== x.irq || bus.busy !== x.busy || bus.vector !== x.vec ||
                bus.pending !== x.pend || bus.enable !== x.en) begin
                errors++;
                $display("FAIL reset_mid c%0d: irq=%b busy=%b vector=%0d pending=%h enable=%h, expected irq=%b busy=%b vector=%0d pending=%h enable=%h",
                         c, bus.irq, bus.busy, bus.vector, bus.pending, bus.enable, x.irq, x.busy, x.vec, x.pend, x.en);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        src = 16'h0000;
        quiet();
        test_reset();
        test_single();
        test_priority();
        test_preempt();
        test_masking();
        test_set_wins();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

- Edge-triggered interrupt controller for up to 2^WIDTH sources.
- Latches source events into a pending register and masks them with an enable register.
- Selects the highest-numbered active source with a `prio_enc` instance and presents one request with its vector to the CPU.
- Sequences the request through an acknowledge / end-of-interrupt handshake, so the CPU sees one interrupt at a time.

## Interface

- `WIDTH`, 4, vector width; number of sources N = 1<<WIDTH
- `clk`  in  1  system clock; all state changes on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `src`  in  N  interrupt source levels; a 0→1 transition is an event
- `en_we`  in  1  write strobe for the enable register
- `en_wdata`  in  N  new enable mask, loaded when `en_we`=1
- `clr_we`  in  1  write strobe for pending-clear
- `clr_wdata`  in  N  write-1-to-clear mask for pending
- `ack`  in  1  CPU accepts the presented interrupt
- `eoi`  in  1  CPU finished servicing
- `irq`  out  1  interrupt request to CPU
- `vector`  out  WIDTH  index of the presented source
- `busy`  out  1  interrupt in service (SERVICE state)
- `pending`  out  N  pending register readback
- `enable`  out  N  enable register readback

## Operation

- Edge detect:
  - `src_q` registers `src` every cycle.
  - event[k] = `src[k]` & ~`src_q[k]`.
  - During `rst`, `src_q` loads `src`, so sources already high at reset release are not events.
- Pending update, per bit, per cycle:
  - An event sets the bit.
  - `clr_we`&`clr_wdata[k]` clears the bit.
  - An accepted `ack` clears bit `vector`.
  - Set wins over any clear in the same cycle, so a new event is never lost.
- Enable: loads `en_wdata` when `en_we`=1. Enable and clear writes in the same cycle both take effect.
- Selection:
  - masked = `pending` & `enable`, using current register values.
  - sel = `prio_enc`(masked): the highest set index wins.
  - any = |masked.
- FSM states: IDLE, REQ, SERVICE. Transitions:
  - IDLE: any=1 → REQ, `vector`<=sel. Otherwise stay.
  - REQ, `ack`=1 → SERVICE. Clear pending[`vector`]; `vector` holds. `ack` has priority over everything else in REQ.
  - REQ, `ack`=0, any=1 → stay in REQ and `vector`<=sel, so a higher source preempts the vector before acknowledge.
  - REQ, `ack`=0, any=0 → IDLE. This covers a request withdrawn by clear or by disable.
  - SERVICE: `eoi`=1 → IDLE. Otherwise stay; `vector` holds.
- Ignored inputs: `ack` outside REQ, and `eoi` outside SERVICE.
- Decoded outputs: `irq` = (state==REQ); `busy` = (state==SERVICE). Both come straight from registered state, with no combinational input-to-output path.
- Events arriving during SERVICE accumulate in pending. They are presented after `eoi`.
- No nesting: at most one interrupt is in service at any time.

## Timing

- Reset values: `irq`=0, `busy`=0, `vector`=0, `pending`=0, `enable`=0, state IDLE.
- Event latency with the source already enabled:
  - `src` rises before edge E0 → pending[k]=1 after E0.
  - REQ entered, `irq`=1 and `vector` valid after E1.
  - Total: 2 cycles from event to `irq`.
- `ack` is sampled at edge Ea while `irq`=1. After Ea: `irq`=0, `busy`=1, pending bit cleared.
- `eoi` is sampled at edge Ee. After Ee: `busy`=0. If other bits remain pending and enabled, `irq`=1 after Ee+1.
- `vector` is registered and stable in any cycle where `irq`=1 and `ack` is asserted.
- Enabling an already-pending source produces `irq` 2 cycles after the `en_we` edge.
- `rst` asserted mid-handshake forces reset values on the next edge. An `ack` or `eoi` in that cycle has no effect.
- Pending retains events of disabled sources. Disabling a source masks it; it does not clear it.

## Test plan

- WIDTH=4, `en_wdata`=16'hFFFF. Pulse `src[5]` → `irq`=1, `vector`=5, exactly 2 cycles after the rise. `ack` → `pending`=0, `busy`=1. `eoi` → `busy`=0, `irq` stays 0.
- Raise `src[3]` and `src[12]` together → `vector`=12. Then `ack`, `eoi` → `irq` re-asserts 1 cycle later with `vector`=3.
- With `vector`=3 presented and no `ack`, pulse `src[9]` → `vector` becomes 9 while `irq` stays 1. `ack` clears bit 9 only, and `pending`=16'h0008.
- Enable 16'h0000, then pulse `src[7]` → `pending`=16'h0080, `irq`=0. Write enable 16'h0080 → `irq` 2 cycles later. Write `clr_wdata`=16'h0080 before `ack` → `irq` drops, state IDLE.
- In the same cycle, `clr_we` with 16'h0010 plus a rising `src[4]` → `pending[4]`=1 (set wins). `ack` of vector 4 coinciding with a new `src[4]` rise → bit stays 1, and it is re-presented after `eoi`.
- Hold `src[2]`=1 through reset → no event after release. Assert `rst` while in SERVICE → next cycle `busy`=0, `irq`=0, `pending`=0, `enable`=0.
